// File: rtl/usb_hid_led_sched.sv
// Schedules HID LED SET_REPORT requests: tracks a target LED value, retries on timeout, flags failure.
// Optional USB_HID_LED_AUTOLOCK_EN: lock keys in keyboard reports toggle their target bits.
module usb_hid_led_sched #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic       usbclk,
    input  logic       usbrst_n,
    input  logic [1:0] typ,
    input  logic       report,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    input  logic       cpu_leds_wr,
    input  logic [3:0] cpu_leds_wdata,
    output logic [3:0] leds,
    output logic       update_leds_stb,
    input  logic       ack_update_leds_stb,
    output logic [3:0] leds_state,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, REQ, BACKOFF} state_t;

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  RETRY_LIM = 8'(MAX_RETRY);

    state_t      state_q, state_d;
    logic [3:0]  target_q, target_d;
    logic [3:0]  leds_q, leds_d;
    logic        dirty_q, dirty_d;
    logic        stb_q, stb_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;
    logic        kbd_q;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  retry_q, retry_d;
    logic        kbd;
    logic        retrig;

    assign kbd = (typ == 2'd1);

`ifdef USB_HID_LED_AUTOLOCK_EN
    localparam logic [7:0] LOCK_CODE [3] = '{8'h53, 8'h39, 8'h47};
    logic [2:0] hist_q, hist_d;
    logic [2:0] lock_present;

    for (genvar gi = 0; gi < 3; gi++) begin : g_lock
        assign lock_present[gi] = (key1 == LOCK_CODE[gi]) || (key2 == LOCK_CODE[gi]) ||
                                  (key3 == LOCK_CODE[gi]) || (key4 == LOCK_CODE[gi]);
    end

    always_comb begin
        target_d = target_q;
        hist_d   = hist_q;
        if (report && kbd) begin
            hist_d = lock_present;
            if (!cpu_leds_wr) target_d = target_q ^ {1'b0, lock_present & ~hist_q};
        end
        if (cpu_leds_wr) target_d = cpu_leds_wdata;
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) hist_q <= 3'd0;
        else           hist_q <= hist_d;
    end
`else
    wire unused_keys = ^{report, key1, key2, key3, key4};

    always_comb begin
        target_d = target_q;
        if (cpu_leds_wr) target_d = cpu_leds_wdata;
    end
`endif

    // A real target change or keyboard re-entry re-arms a request even after a failure.
    assign retrig = (target_d != target_q) || (kbd && !kbd_q);

    always_comb begin
        state_d = state_q;
        leds_d  = leds_q;
        stb_d   = stb_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        dirty_d = dirty_q;
        hold_d  = hold_q;
        err_d   = cpu_leds_wr ? 1'b0 : err_q;
        case (state_q)
            IDLE: begin
                if (dirty_q && kbd && !hold_q) begin
                    state_d = REQ;
                    leds_d  = target_q;
                    dirty_d = 1'b0;
                    cnt_d   = 16'd0;
                    stb_d   = 1'b1;
                end
            end
            REQ: begin
                if (!kbd) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    retry_d = 8'd0;
                    dirty_d = 1'b1;
                    cnt_d   = 16'd0;
                end else if (ack_update_leds_stb) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    retry_d = 8'd0;
                end else if (cnt_q == TO_LAST) begin
                    stb_d = 1'b0;
                    cnt_d = 16'd0;
                    if (retry_q == RETRY_LIM) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                        dirty_d = 1'b1;
                        hold_d  = 1'b1;
                        retry_d = 8'd0;
                    end else begin
                        state_d = BACKOFF;
                        retry_d = retry_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            BACKOFF: begin
                if (!kbd) begin
                    state_d = IDLE;
                    retry_d = 8'd0;
                    dirty_d = 1'b1;
                    cnt_d   = 16'd0;
                end else if (cnt_q == 16'd15) begin
                    state_d = REQ;
                    stb_d   = 1'b1;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (retrig) dirty_d = 1'b1;
        if (retrig || cpu_leds_wr) hold_d = 1'b0;
    end

    always_ff @(posedge usbclk or negedge usbrst_n) begin
        if (!usbrst_n) begin
            state_q  <= IDLE;
            target_q <= 4'd0;
            leds_q   <= 4'd0;
            dirty_q  <= 1'b0;
            stb_q    <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
            kbd_q    <= 1'b0;
            cnt_q    <= 16'd0;
            retry_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            leds_q   <= leds_d;
            dirty_q  <= dirty_d;
            stb_q    <= stb_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
            kbd_q    <= kbd;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
        end
    end

    assign leds            = leds_q;
    assign update_leds_stb = stb_q;
    assign leds_state      = target_q;
    assign busy            = (state_q != IDLE);
    assign err             = err_q;

endmodule
